// File: rtl/q_update_pipeline_pkg.sv
// Shared types, Q12.12 constants and saturating arithmetic helpers for the Q-learning engine.
// Latency: n/a (combinational functions only).
// Backpressure: n/a.
package q_update_pipeline_pkg;

    localparam int Q_W = 24;

    typedef logic signed [Q_W-1:0] q_t;

    // Saturation bounds and the default goal reward (1.0 in Q12.12)
    localparam q_t Q_MAX      = q_t'(24'h7FFFFF);
    localparam q_t Q_MIN      = q_t'(24'h800000);
    localparam q_t REWARD_ONE = q_t'(24'h001000);

    typedef enum logic {
        ACT_LEFT  = 1'b0,
        ACT_RIGHT = 1'b1
    } act_t;

    typedef enum logic [1:0] {
        ST_E1 = 2'd0,
        ST_E2 = 2'd1,
        ST_E3 = 2'd2,
        ST_E4 = 2'd3
    } stage_t;

    // a + b (or a - b when sub=1), clamped to [Q_MIN, Q_MAX]
    function automatic q_t sat_addsub(input q_t a, input q_t b, input logic sub);
        logic [Q_W:0] r;
        if (sub) begin
            r = {a[Q_W-1], a} - {b[Q_W-1], b};
        end else begin
            r = {a[Q_W-1], a} + {b[Q_W-1], b};
        end
        // Overflow shows up as the two top bits disagreeing; top bit gives the direction
        if (r[Q_W] != r[Q_W-1]) begin
            return r[Q_W] ? Q_MIN : Q_MAX;
        end
        return q_t'(r[Q_W-1:0]);
    endfunction

    // x * k with k an unsigned Q0.8 factor; full-width product, then floor shift by 8.
    // |k| < 1.0 so the result always fits back into Q_W bits.
    function automatic q_t mul_q08(input q_t x, input logic [7:0] k);
        logic signed [Q_W+8:0] p;
        p = x * $signed({1'b0, k});
        return q_t'(p[Q_W+7:8]);
    endfunction

endpackage

// File: rtl/q_update_pipeline_lfsr.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) used as the exploration random source.
// Latency: new value visible the cycle after an enabled step.
// Backpressure: holds whenever en is low; reset overrides en.
module q_lfsr8 #(
    parameter logic [7:0] SEED = 8'h01
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    output logic [3:0] pick_o
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;
    logic       fb;

    // Next state: shift left, feedback from taps 8,6,5,4
    always_comb begin
        fb     = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
        lfsr_d = {lfsr_q[6:0], fb};
    end

    // State register, stepped once per enable
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else if (en_i) begin
            lfsr_q <= lfsr_d;
        end
    end

    // Only the low nibble drives the policy (explore flag and random action)
    assign pick_o = lfsr_q[3:0];

endmodule

// File: rtl/q_update_pipeline.sv
// Q-learning update engine on a 1-D chain: Q(s,a) += ALPHA*(r + GAMMA*maxQ(s',.) - Q(s,a)).
// Latency: one update per 4 enabled cycles (E1..E4), write-back and sum on the 4th.
// Backpressure: ce=0 freezes every register; the update resumes exactly where it stopped.
module q_update_pipeline
    import q_update_pipeline_pkg::*;
#(
    parameter int         NUM_STATES = 16,
    parameter logic [7:0] ALPHA      = 8'h40,
    parameter logic [7:0] GAMMA      = 8'hE6,
    parameter q_t         REWARD     = REWARD_ONE,
    parameter int         EPSILON_EN = 1,
    parameter logic [7:0] LFSR_SEED  = 8'h01
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ce,
    output logic signed [Q_W-1:0] sum
);

    localparam int S_W = $clog2(NUM_STATES);
    localparam logic [S_W-1:0] S_TERM = S_W'(NUM_STATES - 1);

    // Q-table and update pipeline state
    q_t             q_tab_q [NUM_STATES][2];
    stage_t         stage_q;
    logic [S_W-1:0] s_q;
    logic [S_W-1:0] sn_q;
    act_t           a_q;
    logic           term_q;
    q_t             qsa_q;
    q_t             qn0_q;
    q_t             qn1_q;
    q_t             t_q;
    q_t             d_q;
    q_t             sum_q;

    // Combinational next values
    logic [3:0]     rnd;
    act_t           a_d;
    logic [S_W-1:0] sn_d;
    logic           term_d;
    q_t             m_d;
    q_t             t_d;
    q_t             d_d;
    q_t             qn_d;

    q_lfsr8 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (ce && (stage_q == ST_E1)),
        .pick_o (rnd)
    );

    // Policy and environment step for the update about to issue
    always_comb begin
        // Greedy choice, ties go right
        a_d = (q_tab_q[s_q][ACT_RIGHT] >= q_tab_q[s_q][ACT_LEFT]) ? ACT_RIGHT : ACT_LEFT;
        if ((EPSILON_EN != 0) && (rnd[2:0] == 3'd0)) begin
            a_d = act_t'(rnd[3]);
        end
        sn_d = '0;
        if (a_d == ACT_RIGHT) begin
            sn_d = s_q + 1'b1;
        end else if (s_q != '0) begin
            sn_d = s_q - 1'b1;
        end
        term_d = (sn_d == S_TERM);
    end

    // Datapath arithmetic for E2..E4, using values latched by earlier stages
    always_comb begin
        m_d  = '0;
        if (!term_q) begin
            m_d = (qn0_q > qn1_q) ? qn0_q : qn1_q;
        end
        t_d  = sat_addsub(term_q ? REWARD : q_t'(0), mul_q08(m_d, GAMMA), 1'b0);
        d_d  = mul_q08(sat_addsub(t_q, qsa_q, 1'b1), ALPHA);
        qn_d = sat_addsub(qsa_q, d_q, 1'b0);
    end

    // Stage sequencer, Q-table write-back and registered output
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_q <= ST_E1;
            s_q     <= '0;
            sn_q    <= '0;
            a_q     <= ACT_LEFT;
            term_q  <= 1'b0;
            qsa_q   <= '0;
            qn0_q   <= '0;
            qn1_q   <= '0;
            t_q     <= '0;
            d_q     <= '0;
            sum_q   <= '0;
            for (int i = 0; i < NUM_STATES; i++) begin
                q_tab_q[i][0] <= '0;
                q_tab_q[i][1] <= '0;
            end
        end else if (ce) begin
            case (stage_q)
                ST_E1: begin
                    a_q     <= a_d;
                    sn_q    <= sn_d;
                    term_q  <= term_d;
                    qsa_q   <= q_tab_q[s_q][a_d];
                    qn0_q   <= q_tab_q[sn_d][0];
                    qn1_q   <= q_tab_q[sn_d][1];
                    stage_q <= ST_E2;
                end
                ST_E2: begin
                    t_q     <= t_d;
                    stage_q <= ST_E3;
                end
                ST_E3: begin
                    d_q     <= d_d;
                    stage_q <= ST_E4;
                end
                default: begin
                    // s_q is untouched since E1, so it still addresses Q(s,a)
                    q_tab_q[s_q][a_q] <= qn_d;
                    sum_q             <= qn_d;
                    s_q               <= term_q ? '0 : sn_q;
                    stage_q           <= ST_E1;
                end
            endcase
        end
    end

    assign sum = sum_q;

endmodule

// File: tb/tb_q_update_pipeline.sv
// Self-checking bench: a greedy and an exploring instance run side by side against a
// behavioural model updated once per 4 enabled edges; sum is compared on every edge.
// ce patterns: always-on, 2-high/1-low, random; resets at rest and mid-update.
module tb_q_update_pipeline;

    localparam int N = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               ce;
    logic signed [23:0] sum_g;
    logic signed [23:0] sum_e;

    always #5 clk = ~clk;

    q_update_pipeline #(
        .EPSILON_EN (0)
    ) dut_g (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (ce),
        .sum   (sum_g)
    );

    q_update_pipeline #(
        .EPSILON_EN (1),
        .LFSR_SEED  (8'h01)
    ) dut_e (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (ce),
        .sum   (sum_e)
    );

    int checks   = 0;
    int failures = 0;

    // Model state: index 0 = greedy instance, 1 = exploring instance
    longint      mq [2][N][2];
    int          ms [2];
    logic [7:0]  ml [2];
    logic [23:0] exp_sum [2];
    int          en_cnt;
    int          upd_e;

    task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (enabled edge %0d)", tag, got, exp, en_cnt);
        end
    endtask

    function automatic longint sat(input longint v);
        if (v > 64'sd8388607)  return 64'sd8388607;
        if (v < -64'sd8388608) return -64'sd8388608;
        return v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int s = 0; s < N; s++) begin
                mq[i][s][0] = 0;
                mq[i][s][1] = 0;
            end
            ms[i]      = 0;
            ml[i]      = 8'h01;
            exp_sum[i] = 24'h0;
        end
        en_cnt = 0;
        upd_e  = 0;
    endfunction

    // One complete Q update, straight from the update rule
    function automatic logic [23:0] model_update(input int i, input bit eps);
        int         s, a, sn;
        bit         term;
        logic [7:0] l;
        longint     r, m, g, t, td, d, qn, qsa;
        s = ms[i];
        l = ml[i];
        a = (mq[i][s][1] >= mq[i][s][0]) ? 1 : 0;
        if (eps && (l[2:0] == 3'd0)) a = int'(l[3]);
        ml[i] = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        sn   = (a == 1) ? s + 1 : ((s > 0) ? s - 1 : 0);
        term = (sn == N - 1);
        r    = term ? 64'sd4096 : 64'sd0;
        m    = 0;
        if (!term) m = (mq[i][sn][0] > mq[i][sn][1]) ? mq[i][sn][0] : mq[i][sn][1];
        g    = (m * 230) >>> 8;
        t    = sat(r + g);
        qsa  = mq[i][s][a];
        td   = sat(t - qsa);
        d    = (td * 64) >>> 8;
        qn   = sat(qsa + d);
        mq[i][s][a] = qn;
        ms[i] = term ? 0 : sn;
        return 24'(qn);
    endfunction

    // One clock: drive at negedge, sample 1 time unit after the rising edge
    task automatic step(input bit ce_v, input bit rst_v);
        @(negedge clk);
        ce    = ce_v;
        rst_n = !rst_v;
        @(posedge clk);
        #1;
        if (rst_v) begin
            model_reset();
            chk("reset_sum_g", sum_g, 24'h0);
            chk("reset_sum_e", sum_e, 24'h0);
        end else if (ce_v) begin
            en_cnt++;
            if ((en_cnt % 4) == 0) begin
                exp_sum[0] = model_update(0, 1'b0);
                exp_sum[1] = model_update(1, 1'b1);
                upd_e++;
            end
            chk("sum_greedy", sum_g, exp_sum[0]);
            chk("sum_explore", sum_e, exp_sum[1]);
            case (en_cnt)
                56:  chk("pre_goal_zero", sum_g, 24'h000000);
                60:  chk("first_goal", sum_g, 24'h000400);
                116: chk("ep2_s13", sum_g, 24'h0000E6);
                120: chk("ep2_goal", sum_g, 24'h000700);
                default: ;
            endcase
        end else begin
            chk("ce_low_hold_g", sum_g, exp_sum[0]);
            chk("ce_low_hold_e", sum_e, exp_sum[1]);
        end
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0;
        ce    = 1'b1;
        model_reset();

        // Reset with ce high, then an ungated run through two episodes
        repeat (3) step(1'b1, 1'b1);
        repeat (200) step(1'b1, 1'b0);

        // ce 2 high / 1 low
        for (int c = 0; c < 300; c++) step(c % 3 != 2, 1'b0);

        // Reset with a populated table, rerun to E2 of update 15, reset where E3 would occur
        step(1'b1, 1'b1);
        repeat (58) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        repeat (130) step(1'b1, 1'b0);

        // Fresh start, 2000 updates under random ce
        step(1'b1, 1'b1);
        cyc = 0;
        while ((upd_e < 2000) && (cyc < 20000)) begin
            step($urandom_range(0, 3) != 0, 1'b0);
            cyc++;
        end
        chk("explore_update_count", 24'(upd_e), 24'd2000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
